// File: rtl/vec_add_join_10.sv
// Joins independently arriving A/B operand vectors, adds element-wise and holds the sums under valid/ack.
// Optional macro VECADD_SATURATE_EN: clamp sums to IN_WIDTH bits and flag saturation on ovfSticky.
module vec_add_join_10 #(
  parameter int IN_WIDTH  = 10,
  parameter int CNT_WIDTH = 16,
`ifdef VECADD_SATURATE_EN
  localparam int OUT_WIDTH = IN_WIDTH
`else
  localparam int OUT_WIDTH = IN_WIDTH + 1
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        aReady,
  input  logic signed [IN_WIDTH-1:0]  A0, A1, A2, A3, A4, A5, A6, A7, A8, A9,
  output logic                        aAccept,
  input  logic                        bReady,
  input  logic signed [IN_WIDTH-1:0]  B0, B1, B2, B3, B4, B5, B6, B7, B8, B9,
  output logic                        bAccept,
  output logic signed [OUT_WIDTH-1:0] S0, S1, S2, S3, S4, S5, S6, S7, S8, S9,
  output logic                        sOutValid,
  input  logic                        sOutAck,
  output logic [CNT_WIDTH-1:0]        vecCount,
  output logic                        ovfSticky
);

  typedef enum logic [1:0] {EMPTY, HAVE_A, HAVE_B, HAVE_AB} joinState_t;

  joinState_t state, stateNext;

  logic signed [IN_WIDTH-1:0]  aIn [10];
  logic signed [IN_WIDTH-1:0]  bIn [10];
  logic signed [IN_WIDTH-1:0]  aBuf [10];
  logic signed [IN_WIDTH-1:0]  bBuf [10];
  logic signed [IN_WIDTH:0]    wide [10];
  logic signed [OUT_WIDTH-1:0] sumNext [10];
  logic signed [OUT_WIDTH-1:0] sReg [10];

  logic aFull, bFull, aFullNext, bFullNext;
  logic capA, capB, fire, resultTaken;

  assign aIn = '{A0, A1, A2, A3, A4, A5, A6, A7, A8, A9};
  assign bIn = '{B0, B1, B2, B3, B4, B5, B6, B7, B8, B9};

  assign aFull = (state == HAVE_A) || (state == HAVE_AB);
  assign bFull = (state == HAVE_B) || (state == HAVE_AB);

  assign aAccept     = enable & ~aFull;
  assign bAccept     = enable & ~bFull;
  assign capA        = aReady & aAccept;
  assign capB        = bReady & bAccept;
  assign fire        = enable & aFull & bFull & (~sOutValid | sOutAck);
  assign resultTaken = enable & sOutValid & sOutAck;

  // Capture needs an empty side and fire needs a full one, so they never coincide on a side.
  always_comb begin
    aFullNext = capA | (aFull & ~fire);
    bFullNext = capB | (bFull & ~fire);
    stateNext = EMPTY;
    unique case ({aFullNext, bFullNext})
      2'b00:   stateNext = EMPTY;
      2'b10:   stateNext = HAVE_A;
      2'b01:   stateNext = HAVE_B;
      default: stateNext = HAVE_AB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else if (enable) begin
      state <= stateNext;
    end
  end

`ifdef VECADD_SATURATE_EN
  logic anyClamp;
`endif

  always_comb begin
`ifdef VECADD_SATURATE_EN
    anyClamp = 1'b0;
`endif
    for (int unsigned i = 0; i < 10; i++) begin
      wide[i] = {aBuf[i][IN_WIDTH-1], aBuf[i]} + {bBuf[i][IN_WIDTH-1], bBuf[i]};
`ifdef VECADD_SATURATE_EN
      if (wide[i][IN_WIDTH] != wide[i][IN_WIDTH-1]) begin
        anyClamp   = 1'b1;
        sumNext[i] = wide[i][IN_WIDTH] ? {1'b1, {(IN_WIDTH-1){1'b0}}}
                                       : {1'b0, {(IN_WIDTH-1){1'b1}}};
      end else begin
        sumNext[i] = wide[i][IN_WIDTH-1:0];
      end
`else
      sumNext[i] = wide[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sOutValid <= 1'b0;
      vecCount  <= '0;
      for (int unsigned i = 0; i < 10; i++) begin
        aBuf[i] <= '0;
        bBuf[i] <= '0;
        sReg[i] <= '0;
      end
    end else if (enable) begin
      if (capA) aBuf <= aIn;
      if (capB) bBuf <= bIn;
      if (fire) begin
        sReg      <= sumNext;
        sOutValid <= 1'b1;
      end else if (resultTaken) begin
        sOutValid <= 1'b0;
      end
      if (resultTaken) vecCount <= vecCount + CNT_WIDTH'(1);
    end
  end

`ifdef VECADD_SATURATE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovfSticky <= 1'b0;
    end else if (fire && anyClamp) begin
      ovfSticky <= 1'b1;
    end
  end
`else
  assign ovfSticky = 1'b0;
`endif

  assign S0 = sReg[0];
  assign S1 = sReg[1];
  assign S2 = sReg[2];
  assign S3 = sReg[3];
  assign S4 = sReg[4];
  assign S5 = sReg[5];
  assign S6 = sReg[6];
  assign S7 = sReg[7];
  assign S8 = sReg[8];
  assign S9 = sReg[9];

endmodule
